// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a power-of-two circular FIFO feeds a
// start/data/stop serializer whose line output comes straight from a flop.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ  = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(BUFFER_SIZE):0]   count,
    output logic                           busy,
    output logic                           tx
);

    localparam int DIV_RAW = CLOCK_FREQ / BAUD_RATE;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(BUFFER_SIZE);
    localparam int CW      = PTR_W + 1;
    localparam int DIV_M1  = DIV - 1;

    localparam logic [CNT_W-1:0] CNT_LAST = DIV_M1[CNT_W-1:0];
    localparam logic [CW-1:0]    FULL_CNT = BUFFER_SIZE[CW-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  baud_cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              busy_q;

    logic [7:0]        mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              wr_accept;
    logic              bit_end;
    logic              pop;

    // full is taken from the registered count, so a write on a popping edge
    // while full is still dropped.
    always_comb begin
        wr_accept = wr_en && (count_q != FULL_CNT);
        bit_end   = (baud_cnt_q == CNT_LAST);
        pop       = (count_q != '0) &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_accept) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_cnt_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        // Chain straight into the next start bit when bytes wait.
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign busy  = busy_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: DIV=8/depth-4 instance plus a DIV=3
// instance; transmitted frames are checked against a queue of written bytes.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, tx;
    logic [2:0] count;

    logic       wr_en5 = 1'b0;
    logic [7:0] wr_data5 = 8'h00;
    logic       full5, empty5, busy5, tx5;
    logic [2:0] count5;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [7:0] exp_q[$];

    uart_tx_buffered #(.CLOCK_FREQ(8), .BAUD_RATE(1), .BUFFER_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy), .tx(tx)
    );

    uart_tx_buffered #(.CLOCK_FREQ(10), .BAUD_RATE(3), .BUFFER_SIZE(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_data(wr_data5),
        .full(full5), .empty(empty5), .count(count5), .busy(busy5), .tx(tx5)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_en   = 1'b0;
        wr_data = 8'($urandom_range(0, 255));
    endtask

    // pre > 0: the start bit is already on the line and the current sample
    // is its pre-th sample.
    task automatic recv_frame(input int max_wait, input int pre);
        logic [7:0] smp;
        logic [7:0] exp_b;
        logic [7:0] got;
        int w;
        smp = '0;
        got = '0;
        if (pre == 0) begin
            tick();
            w = 0;
            while (tx !== 1'b0 && w < max_wait) begin
                tick();
                w++;
            end
            smp[0] = tx;
            for (int k = 1; k < 8; k++) begin
                tick();
                smp[k] = tx;
            end
        end else begin
            smp[pre-1] = tx;
            for (int k = pre; k < 8; k++) begin
                tick();
                smp[k] = tx;
            end
        end
        check("start_bit", smp, 8'h00);
        check("sb_nonempty", (exp_q.size() > 0), 1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                smp[k] = tx;
            end
            check($sformatf("data_bit%0d", i), smp, {8{exp_b[i]}});
            got[i] = smp[4];
        end
        check("frame_byte", got, exp_b);
        for (int k = 0; k < 8; k++) begin
            tick();
            smp[k] = tx;
        end
        check("stop_bit", smp, 8'hFF);
    endtask

    task automatic frame5(input logic [7:0] d);
        logic [31:0] vec;
        logic [31:0] exp_vec;
        int nb;
        int b;
        wr_en5   = 1'b1;
        wr_data5 = d;
        tick();
        wr_en5   = 1'b0;
        wr_data5 = 8'($urandom_range(0, 255));
        vec = '0;
        exp_vec = '0;
        nb = 0;
        for (int s = 0; s < 30; s++) begin
            b = s / 3;
            exp_vec[s] = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : d[b-1]);
            tick();
            vec[s] = tx5;
            if (busy5 === 1'b1) nb++;
        end
        check("div3_frame_bits", vec, exp_vec);
        check("div3_busy_cycles", nb, 30);
        tick();
        check("div3_busy_end", busy5, 1'b0);
        check("div3_tx_idle", tx5, 1'b1);
    endtask

    initial begin
        int bad;
        logic [2:0] exp_cnt [6];
        logic       exp_full [6];
        exp_cnt  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 3'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || count !== 3'd0) bad++;
        end
        check("rst_idle_stable", bad, 0);

        // Single byte 0xA5
        write_byte(8'hA5, 1'b1);
        check("single_count_one", count, 3'd1);
        check("single_tx_before", tx, 1'b1);
        recv_frame(0, 0);
        check("single_busy_in_stop", busy, 1'b1);
        check("single_count_zero", count, 3'd0);
        tick();
        check("single_busy_done", busy, 1'b0);
        check("single_tx_idle", tx, 1'b1);
        check("single_empty", empty, 1'b1);

        // Overflow and back-to-back frames
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i + 1), (i < 5));
            check($sformatf("ovf_count_w%0d", i + 1), count, exp_cnt[i]);
            check($sformatf("ovf_full_w%0d", i + 1), full, exp_full[i]);
        end
        check("ovf_not_empty", empty, 1'b0);
        recv_frame(0, 5);
        for (int f = 0; f < 3; f++) recv_frame(0, 0);
        check("ovf_count_before_last", count, 3'd1);
        recv_frame(0, 0);
        check("ovf_empty_after_last", empty, 1'b1);
        tick();
        check("ovf_busy_done", busy, 1'b0);

        // Write while full on the popping stop-bit edge
        write_byte(8'h10, 1'b1);
        write_byte(8'h20, 1'b1);
        write_byte(8'h30, 1'b1);
        write_byte(8'h40, 1'b1);
        write_byte(8'h50, 1'b1);
        check("wf_full", full, 1'b1);
        recv_frame(0, 4);
        check("wf_full_at_stop", full, 1'b1);
        write_byte(8'h77, 1'b0);
        check("wf_count_after_pop", count, 3'd3);
        check("wf_full_cleared", full, 1'b0);
        recv_frame(0, 1);
        for (int f = 0; f < 3; f++) recv_frame(0, 0);
        tick();
        check("wf_busy_done", busy, 1'b0);
        check("wf_empty", empty, 1'b1);
        check("wf_sb_drained", exp_q.size(), 0);

        // Reset during data bit 3 with bytes still queued
        write_byte(8'h3C, 1'b1);
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        check("rmid_count", count, 3'd2);
        repeat (34) tick();
        check("rmid_bit3", tx, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_tx", tx, 1'b1);
        check("rmid_count_cleared", count, 3'd0);
        check("rmid_empty", empty, 1'b1);
        check("rmid_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rmid_quiet_200", bad, 0);
        check("rmid_count_after", count, 3'd0);

        // Reset while the start bit holds the line low
        write_byte(8'h00, 1'b1);
        tick();
        check("rstart_tx_low", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rstart_tx_async", tx, 1'b1);
        check("rstart_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rstart_tx_after", tx, 1'b1);
        check("rstart_count_after", count, 3'd0);

        // Non-integer divisor instance (DIV=3)
        check("div3_idle_tx", tx5, 1'b1);
        frame5(8'hFF);
        frame5(8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
